// File: rtl/rx_word_assembler_pkg.sv
// Shared types and helpers for the byte-to-word assembler: state encoding,
// input mode constants, terminator default and the ASCII hex decoder.
package rx_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        HALT    = 1'b1
    } state_e;

    localparam logic MODE_RAW = 1'b0;
    localparam logic MODE_HEX = 1'b1;

    localparam logic [31:0] END_WORD_DEF = 32'hFFFF_FFFF;

    typedef struct packed {
        logic       valid;
        logic [3:0] nib;
    } hex_nib_t;

    // Map '0'-'9', 'A'-'F', 'a'-'f' to a nibble; anything else is invalid.
    function automatic hex_nib_t hex_decode(input logic [7:0] c);
        hex_nib_t r;
        r.valid = 1'b1;
        r.nib   = 4'h0;
        if (c >= 8'h30 && c <= 8'h39) begin
            r.nib = 4'(c - 8'h30);
        end else if (c >= 8'h41 && c <= 8'h46) begin
            r.nib = 4'(c - 8'h37);
        end else if (c >= 8'h61 && c <= 8'h66) begin
            r.nib = 4'(c - 8'h57);
        end else begin
            r.valid = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with first-word-fall-through head and a
// synchronous clear; a push is accepted when full if a pop happens too.
module sync_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when indices match.
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty_o = (wr_q == rd_q);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else if (clear_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + (AW+1)'(1);
            if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/rx_word_assembler.sv
// Packs UART bytes (raw or ASCII hex) MSB-first into addressed words, queues
// them for the memory loader, and releases the CPU on the terminator word.
module rx_word_assembler
    import rx_pkg::*;
#(
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       FIFO_DEPTH = 4,
    parameter logic [DATA_W-1:0] END_WORD   = DATA_W'(END_WORD_DEF)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              start,
    input  logic [7:0]        din,
    input  logic              mode_hex,
    output logic [DATA_W-1:0] dout,
    output logic [ADDR_W-1:0] rx_address,
    output logic              go,
    input  logic              dout_ready,
    output logic              MIPS_enable,
    output logic              err_char,
    output logic              err_ovf
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned NIBS  = DATA_W / 4;
    localparam int unsigned CNT_W = $clog2(NIBS) + 1;
    localparam int unsigned ENT_W = ADDR_W + DATA_W;

    state_e              state_q;
    logic [CNT_W-1:0]    count_q;
    logic [DATA_W-1:0]   word_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                hex_q;
    logic                mips_en_q;
    logic                err_char_q;
    logic                err_ovf_q;

    hex_nib_t            dec_c;
    logic                hex_sel_c;
    logic                accept_c;
    logic                bad_char_c;
    logic                last_c;
    logic                done_c;
    logic                pop_c;
    logic                push_c;
    logic [DATA_W-1:0]   word_nxt_c;

    logic [ENT_W-1:0]    head;
    logic                fifo_full;
    logic                fifo_empty;

    // Byte acceptance, shift-in and completion decisions for this cycle.
    always_comb begin
        dec_c      = hex_decode(din);
        hex_sel_c  = (count_q == '0) ? mode_hex : hex_q;
        accept_c   = start && (state_q == COLLECT) && !flush;
        bad_char_c = accept_c && (hex_sel_c == MODE_HEX) && !dec_c.valid;
        if (hex_sel_c == MODE_HEX) begin
            word_nxt_c = {word_q[DATA_W-5:0], dec_c.nib};
            last_c     = (count_q == CNT_W'(NIBS - 1));
        end else begin
            word_nxt_c = {word_q[DATA_W-9:0], din};
            last_c     = (count_q == CNT_W'(BYTES - 1));
        end
        done_c = accept_c && !bad_char_c && last_c;
        pop_c  = dout_ready && !fifo_empty;
        push_c = done_c && (!fifo_full || pop_c);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= COLLECT;
            count_q    <= '0;
            word_q     <= '0;
            addr_q     <= '0;
            hex_q      <= MODE_RAW;
            mips_en_q  <= 1'b0;
            err_char_q <= 1'b0;
            err_ovf_q  <= 1'b0;
        end else if (flush) begin
            state_q    <= COLLECT;
            count_q    <= '0;
            word_q     <= '0;
            addr_q     <= '0;
            hex_q      <= MODE_RAW;
            mips_en_q  <= 1'b0;
            err_char_q <= 1'b0;
            err_ovf_q  <= 1'b0;
        end else if (accept_c) begin
            hex_q <= hex_sel_c;
            if (bad_char_c) begin
                err_char_q <= 1'b1;
                count_q    <= '0;
                word_q     <= '0;
            end else if (last_c) begin
                count_q <= '0;
                word_q  <= '0;
                if (push_c) begin
                    addr_q <= addr_q + ADDR_W'(1);
                    if (word_nxt_c == END_WORD) begin
                        state_q   <= HALT;
                        mips_en_q <= 1'b1;
                    end
                end else begin
                    err_ovf_q <= 1'b1;
                end
            end else begin
                count_q <= count_q + CNT_W'(1);
                word_q  <= word_nxt_c;
            end
        end
    end

    sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .clear_i (flush),
        .push_i  (push_c),
        .pop_i   (pop_c),
        .wdata_i ({addr_q, word_nxt_c}),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Head is forced to zero while the FIFO holds nothing valid.
    assign go          = !fifo_empty;
    assign dout        = fifo_empty ? '0 : head[DATA_W-1:0];
    assign rx_address  = fifo_empty ? '0 : head[ENT_W-1:DATA_W];
    assign MIPS_enable = mips_en_q;
    assign err_char    = err_char_q;
    assign err_ovf     = err_ovf_q;

endmodule

// File: tb/tb_rx_word_assembler.sv
// Directed bench for rx_word_assembler: a queue-based reference of the
// byte-to-word rules checked every cycle, plus hand-computed spot checks.
module tb_rx_word_assembler;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  din = 8'h00;
    logic        mode_hex = 1'b0;
    logic        dout_ready = 1'b0;
    logic [31:0] dout;
    logic [31:0] rx_address;
    logic        go;
    logic        MIPS_enable;
    logic        err_char;
    logic        err_ovf;

    int total = 0;
    int bad   = 0;

    rx_word_assembler dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .start       (start),
        .din         (din),
        .mode_hex    (mode_hex),
        .dout        (dout),
        .rx_address  (rx_address),
        .go          (go),
        .dout_ready  (dout_ready),
        .MIPS_enable (MIPS_enable),
        .err_char    (err_char),
        .err_ovf     (err_ovf)
    );

    always #5 clk = ~clk;

    // Reference: entries are {address, word}; partial word kept as a number.
    logic [63:0] m_q[$];
    int          m_cnt  = 0;
    bit          m_hex  = 0;
    logic [31:0] m_word = 0;
    logic [31:0] m_addr = 0;
    bit          m_halt = 0, m_mips = 0, m_echar = 0, m_eovf = 0;
    bit          m_pop;
    int          m_nib;
    bit          m_done;

    always @(posedge clk or posedge reset) begin
        if (reset || flush) begin
            m_q.delete();
            m_cnt = 0; m_hex = 0; m_word = 0; m_addr = 0;
            m_halt = 0; m_mips = 0; m_echar = 0; m_eovf = 0;
        end else begin
            m_pop = (m_q.size() != 0) && dout_ready;
            if (m_pop) void'(m_q.pop_front());
            if (start && !m_halt) begin
                if (m_cnt == 0) m_hex = mode_hex;
                m_done = 0;
                if (m_hex) begin
                    if (din >= "0" && din <= "9")      m_nib = int'(din) - 48;
                    else if (din >= "A" && din <= "F") m_nib = int'(din) - 55;
                    else if (din >= "a" && din <= "f") m_nib = int'(din) - 87;
                    else                               m_nib = -1;
                    if (m_nib < 0) begin
                        m_echar = 1; m_cnt = 0; m_word = 0;
                    end else begin
                        m_word = m_word * 16 + 32'(m_nib);
                        m_cnt++;
                        m_done = (m_cnt == 8);
                    end
                end else begin
                    m_word = m_word * 256 + 32'(din);
                    m_cnt++;
                    m_done = (m_cnt == 4);
                end
                if (m_done) begin
                    if (m_q.size() < DEPTH) begin
                        m_q.push_back({m_addr, m_word});
                        if (m_word == 32'hFFFF_FFFF) begin
                            m_halt = 1; m_mips = 1;
                        end
                        m_addr = m_addr + 1;
                    end else begin
                        m_eovf = 1;
                    end
                    m_cnt = 0; m_word = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the reference, just after the edge.
    always @(posedge clk) begin
        #1;
        chk("go", 64'(go), 64'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            chk("dout", 64'(dout), 64'(m_q[0][31:0]));
            chk("rx_address", 64'(rx_address), 64'(m_q[0][63:32]));
        end
        chk("MIPS_enable", 64'(MIPS_enable), 64'(m_mips));
        chk("err_char", 64'(err_char), 64'(m_echar));
        chk("err_ovf", 64'(err_ovf), 64'(m_eovf));
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        start = 1'b1;
        din   = b;
    endtask

    task automatic idle();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
        idle();
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
        idle();
    endtask

    task automatic do_flush();
        @(negedge clk);
        start = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        dout_ready = 1'b1;
        while (go && n < 40) begin
            @(negedge clk);
            n++;
        end
        dout_ready = 1'b0;
        chk("drain_timeout", 64'(go), 64'(0));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_go", 64'(go), 64'(0));
        chk("rst_dout", 64'(dout), 64'(0));
        chk("rst_addr", 64'(rx_address), 64'(0));
        chk("rst_mips", 64'(MIPS_enable), 64'(0));
        chk("rst_errs", 64'({err_char, err_ovf}), 64'(0));

        // Raw word: head valid right after the 4th byte's edge.
        mode_hex = 1'b0;
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        idle();
        chk("raw_go", 64'(go), 64'(1));
        chk("raw_dout", 64'(dout), 64'h12345678);
        chk("raw_addr", 64'(rx_address), 64'(0));
        drain();

        // Hex word, then an invalid char, then a word at the next address.
        mode_hex = 1'b1;
        send_str("DEADbeef");
        chk("hex_dout", 64'(dout), 64'hDEADBEEF);
        chk("hex_addr", 64'(rx_address), 64'(1));
        drain();
        send_str("0000000G");
        chk("bad_char_err", 64'(err_char), 64'(1));
        chk("bad_char_nopush", 64'(go), 64'(0));
        send_str("a1B2c3D4");
        chk("after_err_dout", 64'(dout), 64'hA1B2C3D4);
        chk("after_err_addr", 64'(rx_address), 64'(2));
        drain();

        // Overflow: five words into a four-entry FIFO.
        do_flush();
        mode_hex = 1'b0;
        for (int k = 0; k < 5; k++) send_word({4{8'(k + 1)}});
        chk("ovf_err", 64'(err_ovf), 64'(1));
        chk("ovf_head_addr", 64'(rx_address), 64'(0));
        chk("ovf_head_dout", 64'(dout), 64'h01010101);

        // Push and pop on the same edge while full.
        send_byte(8'hC0); send_byte(8'hC1); send_byte(8'hC2);
        @(negedge clk);
        din = 8'hC3;
        dout_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dout_ready = 1'b0;
        chk("full_pushpop_head", 64'(rx_address), 64'(1));
        drain();
        send_word(32'h0BADF00D);
        chk("post_ovf_addr", 64'(rx_address), 64'(5));
        drain();

        // Mode change mid-word is ignored: 'G','H' taken as raw bytes.
        do_flush();
        mode_hex = 1'b0;
        send_byte(8'h11); send_byte(8'h22);
        @(negedge clk);
        mode_hex = 1'b1;
        din = 8'h47;
        @(negedge clk);
        din = 8'h48;
        idle();
        chk("mode_latch_dout", 64'(dout), 64'h11224748);
        chk("mode_latch_noerr", 64'(err_char), 64'(0));
        drain();

        // Reset in the middle of a word discards the partial bytes.
        mode_hex = 1'b0;
        send_byte(8'hEE); send_byte(8'hDD);
        @(negedge clk);
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        send_word(32'h0A0B0C0D);
        chk("rst_mid_dout", 64'(dout), 64'h0A0B0C0D);
        chk("rst_mid_addr", 64'(rx_address), 64'(0));

        // Terminator halts collection until flush.
        send_word(32'hFFFF_FFFF);
        chk("term_mips", 64'(MIPS_enable), 64'(1));
        drain();
        send_word(32'h55667788);
        chk("halt_nopush", 64'(go), 64'(0));
        do_flush();
        chk("flush_mips", 64'(MIPS_enable), 64'(0));
        send_word(32'hCAFEF00D);
        chk("flush_addr", 64'(rx_address), 64'(0));
        chk("flush_dout", 64'(dout), 64'hCAFEF00D);
        drain();

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
